bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Round-robin arbiter for the shared system bus with 4 masters.
- Selects exactly one bus owner each cycle and drives active-low grants. The granted master's address/data are then steered to the slave address decoder and the slaves.
- Grant is parked on the last owner when idle.
- An optional hold-limit counter forces handover so a master that keeps requesting cannot starve the others.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one owner keeps the grant while others request. 0 disables preemption.
- HOLD_W, 5, width of the hold counter. Must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req_  in  1  master 0 bus request, active low.
- m1_req_  in  1  master 1 bus request, active low.
- m2_req_  in  1  master 2 bus request, active low.
- m3_req_  in  1  master 3 bus request, active low.
- m0_grnt_  out  1  master 0 grant, active low, registered.
- m1_grnt_  out  1  master 1 grant, active low, registered.
- m2_grnt_  out  1  master 2 grant, active low, registered.
- m3_grnt_  out  1  master 3 grant, active low, registered.
- owner  out  2  index of current owner, registered. Drives the master-side bus mux.
- handover  out  1  one-cycle pulse, high in the first cycle after owner changes.

Behaviour:

State:
- owner[1:0] register.
- hold_cnt[HOLD_W-1:0] register.
- Grants and handover are registered. m<owner>_grnt_ = 0; all other grants = 1.
- Exactly one grant is low at all times, including while idle.

Reset (asynchronous, immediate on reset=1, held while reset=1):
- owner = 0, m0_grnt_ = 0, m1..m3_grnt_ = 1.
- hold_cnt = 0, handover = 0.
- An ongoing transfer is abandoned. No pending request is remembered.

Per rising edge (reset=0):
1. cur_req = request of the current owner (active low).
2. others = any other master requesting.
3. expire = (MAX_HOLD != 0) && (hold_cnt >= MAX_HOLD-1) && others.
4. If cur_req && !expire:
   - keep owner.
   - hold_cnt = hold_cnt+1, saturating at MAX_HOLD.
   - handover = 0.
5. Otherwise:
   - Scan owner+1, owner+2, owner+3 (mod 4, wrap 3->0). The first requesting master becomes the new owner.
   - On a change: hold_cnt = 0, handover = 1 next cycle.
   - If no other master requests: keep owner (park). hold_cnt = 0 if owner released, else saturates. handover = 0.
6. The current owner is never in the scan. It cannot win against itself after expiry.

Timing:
- Latency: a request asserted before edge N yields its grant visible right after edge N, when the bus is idle/parked on another master.
- Handover costs no dead cycle: the old grant rises and the new grant falls on the same edge.
- Release: if the owner deasserts req_ before edge N and another master requests, the new grant is visible after edge N.

Preemption:
- With MAX_HOLD = M, the owner holds for at most M consecutive cycles while others wait.
- The preempted master, if still requesting, is served again after the round completes.

Simultaneous requests:
- Resolved purely by rotation distance from the current owner.
- Example: owner 1, requests from 0 and 3 -> grant 3.

Requests from a master while it is not granted have no side effects other than eligibility.

Outputs never glitch: all are flop outputs.

Test Plan:
- Reset: assert reset mid-cycle with owner=2 -> immediately m0_grnt_=0, others 1, owner=0, handover=0. Releasing reset with no requests -> grant stays parked on m0.
- Idle request: owner 0 parked, m2_req_=0 at cycle 5 -> after next edge owner=2, m2_grnt_=0, m0_grnt_=1, handover=1 for exactly one cycle.
- Round-robin: owner 1 releases; m0, m2 and m3 all request together -> grant order 2, 3, 0, each held until its req_ rises.
- Preemption (MAX_HOLD=4): m0 holds req_ low continuously, m1 requests at cycle 0 -> m0 granted 4 cycles total, then m1 granted. When m1 releases with m0 still requesting -> m0 regranted with hold_cnt=0.
- No preemption without contention (MAX_HOLD=4): m3 alone requests for 20 cycles -> grant never leaves m3, handover stays 0, hold_cnt saturates at 4.
- MAX_HOLD=0: m1 requests for 50 cycles while m2 waits -> m1 keeps grant all 50 cycles, m2 granted on the edge after m1_req_ rises.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Shared system bus handshake between the four masters and the round-robin
// arbiter: active-low requests in, active-low grants, owner index and the
// handover pulse out.
interface bus_arbiter_if;
  logic       m0_req_;
  logic       m1_req_;
  logic       m2_req_;
  logic       m3_req_;
  logic       m0_grnt_;
  logic       m1_grnt_;
  logic       m2_grnt_;
  logic       m3_grnt_;
  logic [1:0] owner;
  logic       handover;

  // View of a requesting master (or the bench driving all masters)
  modport master (
    output m0_req_, m1_req_, m2_req_, m3_req_,
    input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, handover
  );

  // View of the arbiter that serves the requests
  modport slave (
    input  m0_req_, m1_req_, m2_req_, m3_req_,
    output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, handover
  );
endinterface

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with active-low grants, parking on the
// last owner when idle and an optional hold limit that forces handover when
// other masters are waiting.
module bus_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);

  localparam logic [1:0]        OWNER_RESET = 2'd0;
  localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
  localparam bit                PREEMPT_EN  = (MAX_HOLD != 0);

  logic [3:0]        req;
  logic [1:0]        owner_q;
  logic [1:0]        next_owner;
  logic [1:0]        scan_owner;
  logic [1:0]        cand;
  logic              found;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_inc;
  logic [HOLD_W-1:0] next_hold;
  logic [3:0]        grnt_q;
  logic              handover_q;
  logic              next_handover;
  logic              cur_req;
  logic              others;
  logic              expire;

  assign req = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};

  // Hold counter increment that saturates at the hold limit
  always_comb begin
    hold_inc = (hold_cnt >= HOLD_MAX) ? HOLD_MAX : hold_cnt + 1'b1;
  end

  // Rotating scan from owner+1; iterating from the farthest distance down
  // lets the nearest requester overwrite earlier candidates
  always_comb begin
    found      = 1'b0;
    scan_owner = owner_q;
    cand       = '0;
    for (int d = 3; d >= 1; d--) begin
      cand = owner_q + 2'(d);
      if (req[cand]) begin
        scan_owner = cand;
        found      = 1'b1;
      end
    end
  end

  // Decide whether the owner keeps the bus, is preempted, or releases it
  always_comb begin
    cur_req       = req[owner_q];
    others        = |(req & ~(4'b0001 << owner_q));
    expire        = PREEMPT_EN && (hold_cnt >= HOLD_LAST) && others;
    next_owner    = owner_q;
    next_hold     = hold_inc;
    next_handover = 1'b0;
    if (!(cur_req && !expire)) begin
      if (found) begin
        next_owner    = scan_owner;
        next_hold     = '0;
        next_handover = 1'b1;
      end else begin
        next_hold     = cur_req ? hold_inc : '0;
      end
    end
  end

  // Register owner, hold count, one-hot-low grants and handover pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q    <= OWNER_RESET;
      hold_cnt   <= '0;
      grnt_q     <= 4'b1110;
      handover_q <= 1'b0;
    end else begin
      owner_q    <= next_owner;
      hold_cnt   <= next_hold;
      grnt_q     <= ~(4'b0001 << next_owner);
      handover_q <= next_handover;
    end
  end

  assign bus.m0_grnt_ = grnt_q[0];
  assign bus.m1_grnt_ = grnt_q[1];
  assign bus.m2_grnt_ = grnt_q[2];
  assign bus.m3_grnt_ = grnt_q[3];
  assign bus.owner    = owner_q;
  assign bus.handover = handover_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: three instances (hold limit 16, 4 and
// disabled) share one set of requests and are compared against a
// rotation-distance reference model.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req_n = 4'hF;

  int pass_cnt = 0;
  int total_cnt = 0;

  int         mh [3] = '{16, 4, 0};
  logic [1:0] m_owner [3];
  int         m_tenure [3];
  logic       m_ho [3];

  logic [6:0] d_state [3];

  bus_arbiter_if if16 ();
  bus_arbiter_if if4 ();
  bus_arbiter_if if0 ();

  assign if16.m0_req_ = req_n[0];
  assign if16.m1_req_ = req_n[1];
  assign if16.m2_req_ = req_n[2];
  assign if16.m3_req_ = req_n[3];
  assign if4.m0_req_  = req_n[0];
  assign if4.m1_req_  = req_n[1];
  assign if4.m2_req_  = req_n[2];
  assign if4.m3_req_  = req_n[3];
  assign if0.m0_req_  = req_n[0];
  assign if0.m1_req_  = req_n[1];
  assign if0.m2_req_  = req_n[2];
  assign if0.m3_req_  = req_n[3];

  assign d_state[0] = {if16.owner, if16.m3_grnt_, if16.m2_grnt_, if16.m1_grnt_, if16.m0_grnt_, if16.handover};
  assign d_state[1] = {if4.owner,  if4.m3_grnt_,  if4.m2_grnt_,  if4.m1_grnt_,  if4.m0_grnt_,  if4.handover};
  assign d_state[2] = {if0.owner,  if0.m3_grnt_,  if0.m2_grnt_,  if0.m1_grnt_,  if0.m0_grnt_,  if0.handover};

  bus_arbiter #(.MAX_HOLD(16), .HOLD_W(5)) u_d16 (.clk(clk), .reset(reset), .bus(if16.slave));
  bus_arbiter #(.MAX_HOLD(4),  .HOLD_W(3)) u_d4  (.clk(clk), .reset(reset), .bus(if4.slave));
  bus_arbiter #(.MAX_HOLD(0),  .HOLD_W(5)) u_d0  (.clk(clk), .reset(reset), .bus(if0.slave));

  always #5 clk = ~clk;

  // Reference model: owner keeps the bus while requesting unless others wait
  // and it has already been visible for MAX_HOLD cycles; otherwise the
  // nearest requester in rotation order from the owner takes over.
  task automatic advance();
    logic [3:0] rq;
    logic [1:0] nxt [3];
    int         nt [3];
    logic       nh [3];
    logic       want;
    logic       waiting;
    int         idx;
    rq = ~req_n;
    for (int k = 0; k < 3; k++) begin
      want    = rq[m_owner[k]];
      waiting = (rq & ~(4'b0001 << m_owner[k])) != 4'b0000;
      nxt[k]  = m_owner[k];
      nt[k]   = 0;
      nh[k]   = 1'b0;
      if (want && !(mh[k] > 0 && waiting && m_tenure[k] + 1 >= mh[k])) begin
        nt[k] = m_tenure[k] + 1;
      end else begin
        for (int d = 3; d >= 1; d--) begin
          idx = (int'(m_owner[k]) + d) % 4;
          if (rq[idx]) nxt[k] = 2'(idx);
        end
        nh[k] = (nxt[k] != m_owner[k]);
      end
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      m_owner[k]  = nxt[k];
      m_tenure[k] = nt[k];
      m_ho[k]     = nh[k];
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      m_owner[k]  = 2'd0;
      m_tenure[k] = 0;
      m_ho[k]     = 1'b0;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] exp_rst;
    exp_rst = {2'd0, 4'b1110, 1'b0};
    req_n = 4'hF;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      total_cnt++;
      if (d_state[k] !== exp_rst) $display("[TB] FAIL reset_initial inst%0d got %b want %b", k, d_state[k], exp_rst);
      else pass_cnt++;
    end
    req_n = 4'b1011;
    advance();
    total_cnt++;
    if (d_state[0][6:5] !== 2'd2) $display("[TB] FAIL reset_setup_owner2 got %0d want 2", d_state[0][6:5]);
    else pass_cnt++;
    #3;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      total_cnt++;
      if (d_state[k] !== exp_rst) $display("[TB] FAIL reset_async inst%0d got %b want %b", k, d_state[k], exp_rst);
      else pass_cnt++;
    end
    req_n = 4'hF;
    do_reset();
    for (int i = 0; i < 3; i++) advance();
    for (int k = 0; k < 3; k++) begin
      total_cnt++;
      if (d_state[k] !== exp_rst) $display("[TB] FAIL reset_parked inst%0d got %b want %b", k, d_state[k], exp_rst);
      else pass_cnt++;
    end
  endtask

  task automatic test_idle_request();
    req_n = 4'hF;
    do_reset();
    for (int i = 0; i < 5; i++) advance();
    req_n = 4'b1011;
    advance();
    for (int k = 0; k < 3; k++) begin
      total_cnt++;
      if (d_state[k] !== {2'd2, 4'b1011, 1'b1}) $display("[TB] FAIL idle_grant inst%0d got %b want %b", k, d_state[k], {2'd2, 4'b1011, 1'b1});
      else pass_cnt++;
    end
    advance();
    for (int k = 0; k < 3; k++) begin
      total_cnt++;
      if (d_state[k] !== {2'd2, 4'b1011, 1'b0}) $display("[TB] FAIL idle_pulse_end inst%0d got %b want %b", k, d_state[k], {2'd2, 4'b1011, 1'b0});
      else pass_cnt++;
    end
    req_n = 4'hF;
    advance();
    for (int k = 0; k < 3; k++) begin
      total_cnt++;
      if (d_state[k] !== {2'd2, 4'b1011, 1'b0}) $display("[TB] FAIL idle_park inst%0d got %b want %b", k, d_state[k], {2'd2, 4'b1011, 1'b0});
      else pass_cnt++;
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] pat [5];
    logic [1:0] exp_own [5];
    logic       exp_ho [5];
    pat     = '{4'b1101, 4'b0010, 4'b0010, 4'b0110, 4'b1110};
    exp_own = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd0};
    exp_ho  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    req_n = 4'hF;
    do_reset();
    for (int s = 0; s < 5; s++) begin
      req_n = pat[s];
      advance();
      for (int k = 0; k < 3; k++) begin
        total_cnt++;
        if (d_state[k] !== {exp_own[s], ~(4'b0001 << exp_own[s]), exp_ho[s]})
          $display("[TB] FAIL round_robin step%0d inst%0d got %b want %b", s, k, d_state[k], {exp_own[s], ~(4'b0001 << exp_own[s]), exp_ho[s]});
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_preempt();
    int cnt;
    int guard;
    req_n = 4'hF;
    do_reset();
    req_n = 4'b1100;
    cnt = 1;
    guard = 0;
    while (d_state[1][6:5] === 2'd0 && guard < 20) begin
      advance();
      guard++;
      if (d_state[1][6:5] === 2'd0) cnt++;
    end
    total_cnt++;
    if (cnt !== 4) $display("[TB] FAIL preempt_hold_cycles got %0d want 4", cnt);
    else pass_cnt++;
    total_cnt++;
    if (d_state[1] !== {2'd1, 4'b1101, 1'b1}) $display("[TB] FAIL preempt_handover got %b want %b", d_state[1], {2'd1, 4'b1101, 1'b1});
    else pass_cnt++;
    total_cnt++;
    if (d_state[2][6:5] !== 2'd0 || d_state[0][6:5] !== 2'd0)
      $display("[TB] FAIL preempt_others_keep got %0d/%0d want 0/0", d_state[0][6:5], d_state[2][6:5]);
    else pass_cnt++;
    advance();
    req_n = 4'b1110;
    advance();
    total_cnt++;
    if (d_state[1] !== {2'd0, 4'b1110, 1'b1}) $display("[TB] FAIL preempt_regrant got %b want %b", d_state[1], {2'd0, 4'b1110, 1'b1});
    else pass_cnt++;
    total_cnt++;
    if (u_d4.hold_cnt !== 3'd0) $display("[TB] FAIL preempt_hold_reset got %0d want 0", u_d4.hold_cnt);
    else pass_cnt++;
  endtask

  task automatic test_no_contention();
    req_n = 4'hF;
    do_reset();
    req_n = 4'b0111;
    for (int i = 0; i < 20; i++) begin
      advance();
      total_cnt++;
      if (d_state[1] !== {2'd3, 4'b0111, (i == 0)})
        $display("[TB] FAIL solo_hold cycle%0d got %b want %b", i, d_state[1], {2'd3, 4'b0111, (i == 0)});
      else pass_cnt++;
    end
    total_cnt++;
    if (u_d4.hold_cnt !== 3'd4) $display("[TB] FAIL solo_saturate got %0d want 4", u_d4.hold_cnt);
    else pass_cnt++;
  endtask

  task automatic test_max_hold_zero();
    req_n = 4'hF;
    do_reset();
    req_n = 4'b1101;
    advance();
    req_n = 4'b1001;
    for (int i = 0; i < 50; i++) begin
      advance();
      total_cnt++;
      if (d_state[2][6:5] !== 2'd1) $display("[TB] FAIL nohold_keep cycle%0d got %0d want 1", i, d_state[2][6:5]);
      else pass_cnt++;
    end
    req_n = 4'b1011;
    advance();
    total_cnt++;
    if (d_state[2] !== {2'd2, 4'b1011, 1'b1}) $display("[TB] FAIL nohold_release got %b want %b", d_state[2], {2'd2, 4'b1011, 1'b1});
    else pass_cnt++;
  endtask

  task automatic test_random();
    req_n = 4'hF;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req_n = 4'($urandom);
      advance();
      for (int k = 0; k < 3; k++) begin
        total_cnt++;
        if (d_state[k] !== {m_owner[k], ~(4'b0001 << m_owner[k]), m_ho[k]})
          $display("[TB] FAIL random cycle%0d inst%0d got %b want %b", i, k, d_state[k], {m_owner[k], ~(4'b0001 << m_owner[k]), m_ho[k]});
        else pass_cnt++;
      end
    end
  endtask

  // Run every scenario in sequence and report
  initial begin
    test_reset();
    test_idle_request();
    test_round_robin();
    test_preempt();
    test_no_contention();
    test_max_hold_zero();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
